// File: rtl/display_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_ctrl_pkg
// Description : Shared state encoding, field limits and edit-target codes for
//               the display mode controller.
// Revision    : 1.0 - initial release
// ============================================================================
package display_ctrl_pkg;

   typedef enum logic [1:0] {
      S_TIME   = 2'd0,
      S_ALARM  = 2'd1,
      S_EDIT_H = 2'd2,
      S_EDIT_M = 2'd3
   } state_t;

   localparam logic [7:0] HOUR_MAX  = 8'd23;
   localparam logic [7:0] MIN_MAX   = 8'd59;

   localparam logic       TGT_TIME  = 1'b0;
   localparam logic       TGT_ALARM = 1'b1;

endpackage : display_ctrl_pkg
`default_nettype wire

// File: rtl/edit_field.sv
`default_nettype none
// ============================================================================
// Module      : edit_field
// Description : 8-bit edit register with load, wrapping increment and
//               wrapping decrement over 0..MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module edit_field #(
   parameter logic [7:0] MAX = 8'd59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       up,
   input  logic       down,
   output logic [7:0] value
);

   logic [7:0] value_q;
   logic [7:0] value_d;

   assign value = value_q;

   // Load wins; an out-of-range loaded value is pulled back into 0..MAX by
   // the first up (to 0) or down (to MAX).
   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (up) begin
         value_d = (value_q >= MAX) ? 8'd0 : value_q + 8'd1;
      end else if (down) begin
         value_d = ((value_q == 8'd0) || (value_q > MAX)) ? MAX : value_q - 8'd1;
      end
   end

   // Field register.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= 8'd0;
      end else begin
         value_q <= value_d;
      end
   end

endmodule : edit_field
`default_nettype wire

// File: rtl/gen_counter.sv
`default_nettype none
// ============================================================================
// Module      : gen_counter
// Description : Generic free-running counter 0..MAX_VAL with synchronous
//               clear and a terminal-count (wrap) flag.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_counter #(
   parameter int BITS    = 26,
   parameter int MAX_VAL = 49_999_999
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            en,
   output logic [BITS-1:0] count,
   output logic            wrap
);

   localparam logic [BITS-1:0] c_max = BITS'(MAX_VAL);

   logic [BITS-1:0] count_q;
   logic [BITS-1:0] count_d;

   // A clear overrides a wrap so the caller never sees both in one cycle.
   assign wrap  = en && !clr && (count_q == c_max);
   assign count = count_q;

   // Next count: clear, wrap to zero, or increment when enabled.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (wrap) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : gen_counter
`default_nettype wire

// File: rtl/display_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_mode_ctrl
// Description : Chooses time / alarm / edit-buffer view for the display,
//               runs the set-mode FSM, blinks the edited field and issues
//               one-cycle commit strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module display_mode_ctrl
   import display_ctrl_pkg::*;
#(
   parameter int BLINK_MAX   = 49_999_999,
   parameter int IDLE_HALVES = 20,
   parameter int CNT_W       = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_mode,
   input  logic        btn_set,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic [7:0]  time_hh,
   input  logic [7:0]  time_mm,
   input  logic [7:0]  alarm_hh,
   input  logic [7:0]  alarm_mm,
   output logic [15:0] disp_word,
   output logic [3:0]  disp_blank,
   output logic [7:0]  wr_hh,
   output logic [7:0]  wr_mm,
   output logic        time_wr,
   output logic        alarm_wr,
   output logic        view_alarm,
   output logic        editing
);

   localparam int              IDLE_W      = $clog2(IDLE_HALVES + 1);
   localparam logic [IDLE_W-1:0] c_idle_last = IDLE_W'(IDLE_HALVES - 1);

   state_t            state_q, state_d;
   logic              tgt_q, tgt_d;
   logic              phase_q, phase_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [7:0]        wr_hh_q, wr_hh_d;
   logic [7:0]        wr_mm_q, wr_mm_d;
   logic              time_wr_q, time_wr_d;
   logic              alarm_wr_q, alarm_wr_d;

   logic              w_any_btn;
   logic              w_act_set, w_act_mode, w_act_up, w_act_down;
   logic              w_wrap, w_timeout, w_load;
   logic [CNT_W-1:0]  w_blink_cnt;
   logic [7:0]        edit_hh, edit_mm;

   // Priority set > mode > up > down; up together with down cancels out.
   assign w_any_btn  = btn_set | btn_mode | btn_up | btn_down;
   assign w_act_set  = btn_set;
   assign w_act_mode = btn_mode & ~btn_set;
   assign w_act_up   = btn_up & ~btn_down & ~btn_set & ~btn_mode;
   assign w_act_down = btn_down & ~btn_up & ~btn_set & ~btn_mode;

   // Wrap is already suppressed by a press, so a press always beats timeout.
   assign w_timeout  = w_wrap && (idle_q == c_idle_last) && (state_q != S_TIME);
   assign w_load     = w_act_set && ((state_q == S_TIME) || (state_q == S_ALARM));

   gen_counter #(
      .BITS    (CNT_W),
      .MAX_VAL (BLINK_MAX)
   ) u_blink_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_any_btn),
      .en    (1'b1),
      .count (w_blink_cnt),
      .wrap  (w_wrap)
   );

   edit_field #(.MAX(HOUR_MAX)) u_edit_hh (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .load_val ((state_q == S_ALARM) ? alarm_hh : time_hh),
      .up       (w_act_up   && (state_q == S_EDIT_H)),
      .down     (w_act_down && (state_q == S_EDIT_H)),
      .value    (edit_hh)
   );

   edit_field #(.MAX(MIN_MAX)) u_edit_mm (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .load_val ((state_q == S_ALARM) ? alarm_mm : time_mm),
      .up       (w_act_up   && (state_q == S_EDIT_M)),
      .down     (w_act_down && (state_q == S_EDIT_M)),
      .value    (edit_mm)
   );

   // Set-mode FSM: view switching, edit entry, abort and commit.
   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      wr_hh_d    = wr_hh_q;
      wr_mm_d    = wr_mm_q;
      time_wr_d  = 1'b0;
      alarm_wr_d = 1'b0;
      case (state_q)
         S_TIME: begin
            if (w_act_set) begin
               tgt_d   = TGT_TIME;
               state_d = S_EDIT_H;
            end else if (w_act_mode) begin
               state_d = S_ALARM;
            end
         end
         S_ALARM: begin
            if (w_act_set) begin
               tgt_d   = TGT_ALARM;
               state_d = S_EDIT_H;
            end else if (w_act_mode || w_timeout) begin
               state_d = S_TIME;
            end
         end
         S_EDIT_H: begin
            if (w_act_set) begin
               state_d = S_EDIT_M;
            end else if (w_act_mode || w_timeout) begin
               state_d = (tgt_q == TGT_ALARM) ? S_ALARM : S_TIME;
            end
         end
         S_EDIT_M: begin
            if (w_act_set) begin
               wr_hh_d    = edit_hh;
               wr_mm_d    = edit_mm;
               time_wr_d  = (tgt_q == TGT_TIME);
               alarm_wr_d = (tgt_q == TGT_ALARM);
               state_d    = (tgt_q == TGT_ALARM) ? S_ALARM : S_TIME;
            end else if (w_act_mode || w_timeout) begin
               state_d = (tgt_q == TGT_ALARM) ? S_ALARM : S_TIME;
            end
         end
         default: state_d = S_TIME;
      endcase
   end

   // Blink phase and idle half-period count; a press restarts both.
   always_comb begin
      phase_d = phase_q;
      idle_d  = idle_q;
      if (w_any_btn) begin
         phase_d = 1'b1;
      end else if (w_wrap) begin
         phase_d = ~phase_q;
      end
      if (w_any_btn || (state_d != state_q)) begin
         idle_d = '0;
      end else if (w_wrap && (idle_q != c_idle_last)) begin
         idle_d = idle_q + 1'b1;
      end
   end

   // Controller state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_TIME;
         tgt_q      <= TGT_TIME;
         phase_q    <= 1'b1;
         idle_q     <= '0;
         wr_hh_q    <= 8'd0;
         wr_mm_q    <= 8'd0;
         time_wr_q  <= 1'b0;
         alarm_wr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tgt_q      <= tgt_d;
         phase_q    <= phase_d;
         idle_q     <= idle_d;
         wr_hh_q    <= wr_hh_d;
         wr_mm_q    <= wr_mm_d;
         time_wr_q  <= time_wr_d;
         alarm_wr_q <= alarm_wr_d;
      end
   end

   // Display word and blank mask straight from registers.
   always_comb begin
      disp_word  = {time_hh, time_mm};
      disp_blank = 4'b0000;
      case (state_q)
         S_ALARM:  disp_word = {alarm_hh, alarm_mm};
         S_EDIT_H: begin
            disp_word  = {edit_hh, edit_mm};
            disp_blank = {~phase_q, ~phase_q, 2'b00};
         end
         S_EDIT_M: begin
            disp_word  = {edit_hh, edit_mm};
            disp_blank = {2'b00, ~phase_q, ~phase_q};
         end
         default: ;
      endcase
   end

   assign editing    = (state_q == S_EDIT_H) || (state_q == S_EDIT_M);
   assign view_alarm = (state_q == S_ALARM) || (editing && (tgt_q == TGT_ALARM));
   assign wr_hh      = wr_hh_q;
   assign wr_mm      = wr_mm_q;
   assign time_wr    = time_wr_q;
   assign alarm_wr   = alarm_wr_q;

endmodule : display_mode_ctrl
`default_nettype wire

// File: tb/tb_display_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_mode_ctrl
// Description : Directed self-checking bench for display_mode_ctrl with a
//               short blink period (BLINK_MAX = 3, IDLE_HALVES = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_mode_ctrl;

   localparam logic [3:0] B_SET  = 4'b1000;
   localparam logic [3:0] B_MODE = 4'b0100;
   localparam logic [3:0] B_UP   = 4'b0010;
   localparam logic [3:0] B_DOWN = 4'b0001;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_mode, btn_set, btn_up, btn_down;
   logic [7:0]  time_hh, time_mm, alarm_hh, alarm_mm;
   logic [15:0] disp_word;
   logic [3:0]  disp_blank;
   logic [7:0]  wr_hh, wr_mm;
   logic        time_wr, alarm_wr, view_alarm, editing;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   display_mode_ctrl #(
      .BLINK_MAX   (3),
      .IDLE_HALVES (2),
      .CNT_W       (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_mode   (btn_mode),
      .btn_set    (btn_set),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .time_hh    (time_hh),
      .time_mm    (time_mm),
      .alarm_hh   (alarm_hh),
      .alarm_mm   (alarm_mm),
      .disp_word  (disp_word),
      .disp_blank (disp_blank),
      .wr_hh      (wr_hh),
      .wr_mm      (wr_mm),
      .time_wr    (time_wr),
      .alarm_wr   (alarm_wr),
      .view_alarm (view_alarm),
      .editing    (editing)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle button pulse, visible in outputs when the task returns.
   task automatic press(input logic [3:0] b);
      {btn_set, btn_mode, btn_up, btn_down} = b;
      tick(1);
      {btn_set, btn_mode, btn_up, btn_down} = 4'b0000;
   endtask

   initial begin
      rst = 1'b1;
      {btn_set, btn_mode, btn_up, btn_down} = 4'b0000;
      time_hh = 8'd13; time_mm = 8'd45;
      alarm_hh = 8'd6; alarm_mm = 8'd30;
      tick(2);
      rst = 1'b0;
      chk("rst_word",  32'(disp_word), {16'd0, 8'd13, 8'd45});
      chk("rst_blank", 32'(disp_blank), 32'd0);
      chk("rst_edit",  32'(editing), 32'd0);
      chk("rst_view",  32'(view_alarm), 32'd0);
      chk("rst_twr",   32'(time_wr), 32'd0);
      chk("rst_wrhh",  32'(wr_hh), 32'd0);

      // Mode toggles time / alarm view.
      press(B_MODE);
      chk("alarm_word", 32'(disp_word), {16'd0, 8'd6, 8'd30});
      chk("alarm_view", 32'(view_alarm), 32'd1);
      press(B_MODE);
      chk("time_word", 32'(disp_word), {16'd0, 8'd13, 8'd45});
      chk("time_view", 32'(view_alarm), 32'd0);

      // Time edit 23:59 -> 00:00 with wraps.
      time_hh = 8'd23; time_mm = 8'd59;
      press(B_SET);
      chk("t_edit_on", 32'(editing), 32'd1);
      chk("t_edit_word", 32'(disp_word), {16'd0, 8'd23, 8'd59});
      press(B_UP);
      chk("hh_wrap_up", 32'(disp_word), {16'd0, 8'd0, 8'd59});
      press(B_SET);
      press(B_UP);
      chk("mm_wrap_up", 32'(disp_word), {16'd0, 8'd0, 8'd0});
      press(B_SET);
      chk("t_commit_twr", 32'(time_wr), 32'd1);
      chk("t_commit_awr", 32'(alarm_wr), 32'd0);
      chk("t_commit_hh",  32'(wr_hh), 32'd0);
      chk("t_commit_mm",  32'(wr_mm), 32'd0);
      chk("t_commit_edit", 32'(editing), 32'd0);
      chk("t_commit_view", 32'(view_alarm), 32'd0);
      chk("t_commit_word", 32'(disp_word), {16'd0, 8'd23, 8'd59});
      tick(1);
      chk("t_strobe_1cyc", 32'(time_wr), 32'd0);

      // Alarm edit 00:00 -> 23:58 with down wraps.
      alarm_hh = 8'd0; alarm_mm = 8'd0;
      press(B_MODE);
      chk("a_view", 32'(view_alarm), 32'd1);
      press(B_SET);
      chk("a_edit_on", 32'(editing), 32'd1);
      chk("a_edit_view", 32'(view_alarm), 32'd1);
      press(B_DOWN);
      chk("hh_wrap_dn", 32'(disp_word), {16'd0, 8'd23, 8'd0});
      press(B_SET);
      press(B_DOWN);
      press(B_DOWN);
      chk("mm_dn2", 32'(disp_word), {16'd0, 8'd23, 8'd58});
      press(B_SET);
      chk("a_commit_awr", 32'(alarm_wr), 32'd1);
      chk("a_commit_twr", 32'(time_wr), 32'd0);
      chk("a_commit_hh",  32'(wr_hh), 32'd23);
      chk("a_commit_mm",  32'(wr_mm), 32'd58);
      chk("a_commit_view", 32'(view_alarm), 32'd1);
      chk("a_commit_edit", 32'(editing), 32'd0);
      tick(1);
      chk("a_strobe_1cyc", 32'(alarm_wr), 32'd0);
      chk("a_wr_hold", 32'(wr_hh), 32'd23);

      // Idle timeout in S_ALARM: 8 cycles after commit edge.
      tick(6);
      chk("a_idle_pre", 32'(view_alarm), 32'd1);
      tick(1);
      chk("a_idle_to", 32'(view_alarm), 32'd0);
      chk("a_idle_word", 32'(disp_word), {16'd0, 8'd23, 8'd59});

      // Blink in S_EDIT_H; up in the timeout cycle keeps editing.
      time_hh = 8'd13; time_mm = 8'd45;
      press(B_SET);
      chk("blk_e0", 32'(disp_blank), 32'b0000);
      tick(3);
      chk("blk_e3", 32'(disp_blank), 32'b0000);
      tick(1);
      chk("blk_e4", 32'(disp_blank), 32'b1100);
      tick(3);
      chk("blk_e7", 32'(disp_blank), 32'b1100);
      press(B_UP);
      chk("blk_press", 32'(disp_blank), 32'b0000);
      chk("to_press_edit", 32'(editing), 32'd1);
      chk("to_press_word", 32'(disp_word), {16'd0, 8'd14, 8'd45});

      // up+down cancels; set+mode acts as set.
      press(B_UP | B_DOWN);
      chk("updn_word", 32'(disp_word), {16'd0, 8'd14, 8'd45});
      chk("updn_edit", 32'(editing), 32'd1);
      press(B_SET | B_MODE);
      chk("setmode_edit", 32'(editing), 32'd1);
      press(B_UP);
      chk("setmode_min", 32'(disp_word), {16'd0, 8'd14, 8'd46});

      // Idle timeout in S_EDIT_M aborts without strobe.
      tick(4);
      chk("blk_m_e4", 32'(disp_blank), 32'b0011);
      tick(3);
      chk("m_idle_pre", 32'(editing), 32'd1);
      tick(1);
      chk("m_idle_edit", 32'(editing), 32'd0);
      chk("m_idle_twr", 32'(time_wr), 32'd0);
      chk("m_idle_view", 32'(view_alarm), 32'd0);
      chk("m_idle_word", 32'(disp_word), {16'd0, 8'd13, 8'd45});

      // Out-of-range loaded hours.
      time_hh = 8'd30;
      press(B_SET);
      chk("oor_load", 32'(disp_word), {16'd0, 8'd30, 8'd45});
      press(B_UP);
      chk("oor_up", 32'(disp_word), {16'd0, 8'd0, 8'd45});
      press(B_MODE);
      chk("oor_abort", 32'(editing), 32'd0);
      press(B_SET);
      press(B_DOWN);
      chk("oor_dn", 32'(disp_word), {16'd0, 8'd23, 8'd45});
      press(B_MODE);

      // Reset mid-edit discards the edit.
      time_hh = 8'd13;
      press(B_SET);
      press(B_UP);
      chk("pre_rst_word", 32'(disp_word), {16'd0, 8'd14, 8'd45});
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("mid_rst_edit", 32'(editing), 32'd0);
      chk("mid_rst_word", 32'(disp_word), {16'd0, 8'd13, 8'd45});
      chk("mid_rst_wrhh", 32'(wr_hh), 32'd0);
      tick(1);
      chk("mid_rst_twr", 32'(time_wr), 32'd0);
      chk("mid_rst_awr", 32'(alarm_wr), 32'd0);

      // Mode abort while editing the alarm returns to alarm view.
      press(B_MODE);
      press(B_SET);
      chk("a_abort_on", 32'(editing), 32'd1);
      press(B_MODE);
      chk("a_abort_edit", 32'(editing), 32'd0);
      chk("a_abort_view", 32'(view_alarm), 32'd1);
      chk("a_abort_awr", 32'(alarm_wr), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_display_mode_ctrl
`default_nettype wire

// File: doc/display_mode_ctrl.md
Name: display_mode_ctrl

Overview:
- Controller that decides what the seven-segment display shows: current time, alarm time, or an edit buffer while the user sets either one.
- Sits between the timekeeping/alarm registers and the display block. Drives its hours/minutes word and per-digit blank mask.
- Runs the set-mode state machine, blinks the field being edited, and issues one-cycle write strobes to commit edits.

Parameters:
- BLINK_MAX, 49_999_999, terminal count of the blink half-period counter (0.5 s at 100 MHz).
- IDLE_HALVES, 20, number of blink half-periods with no button press before auto-return (10 s).
- CNT_W, 26, width of the blink counter; must hold BLINK_MAX.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous active-high reset
- btn_mode  in  1  debounced single-cycle pulse
- btn_set  in  1  debounced single-cycle pulse
- btn_up  in  1  debounced single-cycle pulse
- btn_down  in  1  debounced single-cycle pulse
- time_hh  in  8  current hours, binary 0..23
- time_mm  in  8  current minutes, binary 0..59
- alarm_hh  in  8  alarm hours, binary
- alarm_mm  in  8  alarm minutes, binary
- disp_word  out  16  {hours, minutes} binary, fed to the display block
- disp_blank  out  4  per-digit blank, bit3 = leftmost digit
- wr_hh  out  8  committed hours
- wr_mm  out  8  committed minutes
- time_wr  out  1  one-cycle commit strobe to the time registers
- alarm_wr  out  1  one-cycle commit strobe to the alarm registers
- view_alarm  out  1  high in S_ALARM, or while editing the alarm
- editing  out  1  high in S_EDIT_H or S_EDIT_M

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values:
  - state = S_TIME, tgt = 0, edit_hh = edit_mm = 0
  - blink_cnt = 0, phase = 1 (visible), idle_cnt = 0
  - time_wr = alarm_wr = 0, wr_hh = wr_mm = 0
  - Resulting outputs: disp_word = {time_hh, time_mm}, disp_blank = 0.
  - Reset mid-edit discards the edit with no strobe.
- Button priority, applied per cycle: set > mode > up > down. Only the highest-priority asserted button acts. up and down together is a no-op.
- States:
  - S_TIME: mode -> S_ALARM. set -> load edit_hh/edit_mm from time_*, tgt = 0, go to S_EDIT_H.
  - S_ALARM: mode -> S_TIME. set -> load from alarm_*, tgt = 1, go to S_EDIT_H. Idle timeout -> S_TIME.
  - S_EDIT_H: up -> edit_hh+1, wrapping 23->0. down -> edit_hh-1, wrapping 0->23. set -> S_EDIT_M. mode or idle timeout -> abort, no strobe, go to S_TIME (tgt = 0) or S_ALARM (tgt = 1).
  - S_EDIT_M: up/down on edit_mm, wrapping 0..59. set -> commit. mode or idle timeout -> abort as in S_EDIT_H.
- Commit: a set press in S_EDIT_M at cycle N gives, at cycle N+1:
  - wr_hh = edit_hh, wr_mm = edit_mm
  - time_wr (tgt = 0) or alarm_wr (tgt = 1) high for exactly one cycle
  - state is S_TIME or S_ALARM respectively.
  - wr_hh/wr_mm hold their value after the strobe.
- Out-of-range loaded values: up from a value >= max wraps to 0. down from a value > max gives max.
- Display selection, combinational from registers with zero added latency:
  - S_TIME shows time_*.
  - S_ALARM shows alarm_*.
  - Edit states show {edit_hh, edit_mm}.
- Blink:
  - blink_cnt counts 0..BLINK_MAX. phase toggles on wrap.
  - Any button press clears blink_cnt and sets phase = 1, so the edited value is visible immediately.
  - disp_blank = {~phase, ~phase, 0, 0} in S_EDIT_H, {0, 0, ~phase, ~phase} in S_EDIT_M, 0 otherwise.
- Idle timeout:
  - idle_cnt increments on each blink wrap and clears on any button press or state change.
  - Timeout fires when idle_cnt == IDLE_HALVES-1 and a wrap occurs. It is active only in S_ALARM, S_EDIT_H and S_EDIT_M.
  - A button press in the timeout cycle wins; the timeout is ignored.

Decomposition:
- Package display_ctrl_pkg holds:
  - state encoding (S_TIME, S_ALARM, S_EDIT_H, S_EDIT_M, 2 bits)
  - HOUR_MAX = 23, MIN_MAX = 59
  - TGT_TIME = 0, TGT_ALARM = 1
- Sub-module edit_field: 8-bit load/up/down wrap register with a MAX parameter. Instantiated twice, for hours and minutes.
- Blink counter: reuses the team's existing generic counter with BITS = CNT_W and MAX_VAL = BLINK_MAX.

Test Plan:
- Reset then time = 13:45 -> disp_word = {13, 45}, disp_blank = 0, editing = 0. mode -> disp_word = alarm value, view_alarm = 1. mode again -> time view.
- S_TIME at 23:59: set, up -> hours 0. set, up -> minutes 0. set -> time_wr high exactly one cycle, wr_hh = 0, wr_mm = 0, state S_TIME.
- Alarm 00:00: mode, set, down -> hours 23. set, down x2 -> minutes 58. set -> alarm_wr pulse, wr = 23:58, time_wr stays 0, view_alarm = 1.
- Editing, BLINK_MAX = 3 in bench: disp_blank toggles between 1100 and 0000 every 4 cycles in S_EDIT_H. Press up -> blank = 0000 the next cycle.
- Idle in S_EDIT_M with IDLE_HALVES = 2 (BLINK_MAX = 3) -> after 8 cycles returns to the view state, no strobe. up asserted in the timeout cycle -> stays in edit.
- Simultaneous set+mode in S_EDIT_H -> goes to S_EDIT_M. Simultaneous up+down -> value unchanged. rst asserted mid-edit -> S_TIME, no strobe.
